// File: rtl/cmos_rgb565_capture_pkg.sv
// Shared video definitions for the CMOS DVP capture path: RGB565 field layout,
// default line length and sensor settle frame count.
package cmos_rgb565_capture_pkg;

  localparam int unsigned R_W                = 5;
  localparam int unsigned G_W                = 6;
  localparam int unsigned B_W                = 5;
  localparam int unsigned PIX_W              = R_W + G_W + B_W;
  localparam int unsigned LINE_CNT_W         = 12;
  localparam int unsigned DEFAULT_H_ACTIVE   = 640;
  localparam int unsigned DEFAULT_FRAME_SKIP = 10;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } byte_phase_e;

endpackage

// File: rtl/cmos_rgb565_capture.sv
// DVP byte stream to RGB565 pixel capture with settle-frame skipping and
// per-line length checking.
module cmos_rgb565_capture
  import cmos_rgb565_capture_pkg::*;
#(
  parameter int unsigned FRAME_SKIP = DEFAULT_FRAME_SKIP,
  parameter int unsigned H_ACTIVE   = DEFAULT_H_ACTIVE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic [7:0]       cam_data,
  output logic [PIX_W-1:0] rgb_data_o,
  output logic             data_en_o,
  output logic             vs_o,
  output logic             de_o,
  output logic             frame_ready,
  output logic             line_err
);

  localparam int unsigned SKIP_W = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;

  logic                  s1_vsync_q, s1_vsync_d;
  logic                  s1_href_q, s1_href_d;
  logic [7:0]            s1_data_q, s1_data_d;
  logic                  s2_vsync_q, s2_vsync_d;
  logic                  s2_href_q, s2_href_d;
  byte_phase_e           phase_q, phase_d;
  logic [7:0]            hi_byte_q, hi_byte_d;
  rgb565_t               pix_q, pix_d;
  logic                  pix_vld_q, pix_vld_d;
  logic [PIX_W-1:0]      rgb_q, rgb_d;
  logic                  data_en_q, data_en_d;
  logic                  de_q, de_d;
  logic                  ready_q, ready_d;
  logic                  line_err_q, line_err_d;
  logic [SKIP_W-1:0]     skip_cnt_q, skip_cnt_d;
  logic [LINE_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic                  trunc_q, trunc_d;

  logic                  vs_rise, href_rise, href_fall, vs_in_line;
  byte_phase_e           cur_phase;

  always_comb begin
    vs_rise    = s1_vsync_q & ~s2_vsync_q;
    href_rise  = s1_href_q & ~s2_href_q;
    href_fall  = ~s1_href_q & s2_href_q;
    vs_in_line = vs_rise & s1_href_q & s2_href_q;

    s1_vsync_d = cam_vsync;
    s1_href_d  = cam_href;
    s1_data_d  = cam_data;
    s2_vsync_d = s1_vsync_q;
    s2_href_d  = s1_href_q;

    phase_d    = phase_q;
    hi_byte_d  = hi_byte_q;
    pix_d      = pix_q;
    pix_vld_d  = 1'b0;
    pix_cnt_d  = pix_cnt_q;
    trunc_d    = trunc_q;
    skip_cnt_d = skip_cnt_q;
    ready_d    = ready_q;

    if (href_rise) begin
      pix_cnt_d = '0;
      trunc_d   = 1'b0;
    end

    // A frame boundary inside an active line restarts pairing on the current byte
    // and marks the line as truncated so its length is never judged.
    cur_phase = vs_in_line ? PH_HI : phase_q;
    if (vs_in_line) begin
      pix_cnt_d = '0;
      trunc_d   = 1'b1;
    end

    if (!s1_href_q) begin
      phase_d = PH_HI;
    end else if (cur_phase == PH_HI) begin
      hi_byte_d = s1_data_q;
      phase_d   = PH_LO;
    end else begin
      pix_d     = rgb565_t'({hi_byte_q, s1_data_q});
      pix_vld_d = 1'b1;
      phase_d   = PH_HI;
      if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + 1'b1;
    end

    if (vs_rise) begin
      if (skip_cnt_q == SKIP_W'(FRAME_SKIP)) ready_d = 1'b1;
      else                                   skip_cnt_d = skip_cnt_q + 1'b1;
    end

    rgb_d      = pix_vld_q ? pix_q : rgb_q;
    data_en_d  = pix_vld_q & ready_q;
    de_d       = s1_href_q & ready_q;
    line_err_d = href_fall & ready_q & ~trunc_q &
                 (pix_cnt_q != LINE_CNT_W'(H_ACTIVE));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vsync_q <= 1'b0;
      s1_href_q  <= 1'b0;
      s1_data_q  <= '0;
      s2_vsync_q <= 1'b0;
      s2_href_q  <= 1'b0;
      phase_q    <= PH_HI;
      hi_byte_q  <= '0;
      pix_q      <= '0;
      pix_vld_q  <= 1'b0;
      rgb_q      <= '0;
      data_en_q  <= 1'b0;
      de_q       <= 1'b0;
      ready_q    <= 1'b0;
      line_err_q <= 1'b0;
      skip_cnt_q <= '0;
      pix_cnt_q  <= '0;
      trunc_q    <= 1'b0;
    end else begin
      s1_vsync_q <= s1_vsync_d;
      s1_href_q  <= s1_href_d;
      s1_data_q  <= s1_data_d;
      s2_vsync_q <= s2_vsync_d;
      s2_href_q  <= s2_href_d;
      phase_q    <= phase_d;
      hi_byte_q  <= hi_byte_d;
      pix_q      <= pix_d;
      pix_vld_q  <= pix_vld_d;
      rgb_q      <= rgb_d;
      data_en_q  <= data_en_d;
      de_q       <= de_d;
      ready_q    <= ready_d;
      line_err_q <= line_err_d;
      skip_cnt_q <= skip_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      trunc_q    <= trunc_d;
    end
  end

  assign rgb_data_o  = rgb_q;
  assign data_en_o   = data_en_q;
  assign vs_o        = s2_vsync_q;
  assign de_o        = de_q;
  assign frame_ready = ready_q;
  assign line_err    = line_err_q;

endmodule

// File: tb/tb_cmos_rgb565_capture.sv
// Scoreboard bench for cmos_rgb565_capture: expected pixels queued as bytes are
// driven, observed strobes recorded by a monitor and compared per scenario.
module tb_cmos_rgb565_capture;

  localparam int unsigned FS = 2;
  localparam int unsigned HA = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = '0;
  logic [15:0] rgb_data_o;
  logic        data_en_o, vs_o, de_o, frame_ready, line_err;

  int tests_run = 0;
  int failed    = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int obs_rd   = 0;
  int lerr_cnt = 0;

  always #5 clk = ~clk;

  cmos_rgb565_capture #(.FRAME_SKIP(FS), .H_ACTIVE(HA)) dut (
    .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .rgb_data_o(rgb_data_o), .data_en_o(data_en_o),
    .vs_o(vs_o), .de_o(de_o), .frame_ready(frame_ready), .line_err(line_err)
  );

  always @(negedge clk) begin
    if (data_en_o) obs_q.push_back(rgb_data_o);
    if (line_err) lerr_cnt++;
  end

  task automatic drive_idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_line(input int nbytes, input bit keep);
    logic [7:0] b, hi;
    hi = '0;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom);
      @(negedge clk); cam_href = 1'b1; cam_data = b;
      if (i % 2 == 0) hi = b;
      else if (keep) exp_q.push_back({hi, b});
    end
    @(negedge clk); cam_href = 1'b0; cam_data = '0;
    drive_idle(2);
  endtask

  task automatic drive_frame(input int lines, input bit keep);
    @(negedge clk); cam_vsync = 1'b1;
    drive_idle(2);
    @(negedge clk); cam_vsync = 1'b0;
    drive_idle(2);
    for (int l = 0; l < lines; l++) send_line(2 * HA, keep);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle(3);
    cam_vsync = 1'b1; cam_href = 1'b1; cam_data = 8'hA5;
    drive_idle(3);
    tests_run++; if (rgb_data_o !== 16'h0) begin failed++; $display("FAIL reset_rgb: got %h, required 0000", rgb_data_o); end
    tests_run++; if (data_en_o !== 1'b0) begin failed++; $display("FAIL reset_data_en: got %b, required 0", data_en_o); end
    tests_run++; if (vs_o !== 1'b0) begin failed++; $display("FAIL reset_vs: got %b, required 0", vs_o); end
    tests_run++; if (de_o !== 1'b0) begin failed++; $display("FAIL reset_de: got %b, required 0", de_o); end
    tests_run++; if (frame_ready !== 1'b0) begin failed++; $display("FAIL reset_ready: got %b, required 0", frame_ready); end
    tests_run++; if (line_err !== 1'b0) begin failed++; $display("FAIL reset_line_err: got %b, required 0", line_err); end
    cam_vsync = 1'b0; cam_href = 1'b0; cam_data = '0;
    @(negedge clk); rst = 1'b1;
    drive_idle(3);
  endtask

  task automatic test_frame_skip();
    int base, lbase;
    logic [15:0] e;
    for (int f = 1; f <= 3; f++) begin
      base = obs_q.size(); lbase = lerr_cnt;
      @(negedge clk); cam_vsync = 1'b1;
      @(negedge clk);
      tests_run++;
      if (frame_ready !== 1'b0) begin failed++; $display("FAIL skip_ready_pre f%0d: got %b, required 0", f, frame_ready); end
      @(negedge clk);
      tests_run++;
      if (frame_ready !== (f == 3)) begin failed++; $display("FAIL skip_ready_edge f%0d: got %b, required %b", f, frame_ready, (f == 3)); end
      tests_run++;
      if (vs_o !== 1'b1) begin failed++; $display("FAIL skip_vs_o f%0d: got %b, required 1", f, vs_o); end
      @(negedge clk); cam_vsync = 1'b0;
      drive_idle(2);
      for (int l = 0; l < 4; l++) send_line(2 * HA, f == 3);
      drive_idle(4);
      tests_run++;
      if (lerr_cnt != lbase) begin failed++; $display("FAIL skip_line_err f%0d: got %0d pulses, required 0", f, lerr_cnt - lbase); end
      if (f < 3) begin
        tests_run++;
        if (obs_q.size() != base) begin failed++; $display("FAIL skip_strobes f%0d: got %0d, required 0", f, obs_q.size() - base); end
        obs_rd = obs_q.size();
      end else begin
        tests_run++;
        if (obs_q.size() - obs_rd != 4 * HA) begin failed++; $display("FAIL skip_strobes f3: got %0d, required %0d", obs_q.size() - obs_rd, 4 * HA); end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
          e = exp_q.pop_front(); tests_run++;
          if (obs_q[obs_rd] !== e) begin failed++; $display("FAIL skip_pix[%0d]: got %h, required %h", obs_rd, obs_q[obs_rd], e); end
          obs_rd++;
        end
        exp_q.delete(); obs_rd = obs_q.size();
      end
    end
  endtask

  task automatic test_latency();
    logic [7:0] b, hi;
    logic [15:0] e;
    int lbase;
    lbase = lerr_cnt; hi = '0;
    for (int i = 0; i < 2 * HA; i++) begin
      b = (i == 2 * HA - 2) ? 8'hF8 : (i == 2 * HA - 1) ? 8'h1F : 8'($urandom);
      @(negedge clk); cam_href = 1'b1; cam_data = b;
      if (i % 2 == 0) hi = b; else exp_q.push_back({hi, b});
    end
    @(negedge clk); cam_href = 1'b0; cam_data = '0;
    @(negedge clk);
    tests_run++;
    if (data_en_o !== 1'b0) begin failed++; $display("FAIL lat_k1_en: got %b, required 0", data_en_o); end
    @(negedge clk);
    tests_run++;
    if (data_en_o !== 1'b1 || rgb_data_o !== 16'hF81F) begin
      failed++; $display("FAIL lat_k2: got en=%b rgb=%h, required en=1 rgb=f81f", data_en_o, rgb_data_o);
    end
    @(negedge clk);
    tests_run++;
    if (data_en_o !== 1'b0) begin failed++; $display("FAIL lat_k3_en: got %b, required 0", data_en_o); end
    drive_idle(3);
    tests_run++;
    if (lerr_cnt != lbase) begin failed++; $display("FAIL lat_line_err: got %0d pulses, required 0", lerr_cnt - lbase); end
    tests_run++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin failed++; $display("FAIL lat_strobes: got %0d, required %0d", obs_q.size() - obs_rd, exp_q.size()); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); tests_run++;
      if (obs_q[obs_rd] !== e) begin failed++; $display("FAIL lat_pix[%0d]: got %h, required %h", obs_rd, obs_q[obs_rd], e); end
      obs_rd++;
    end
    exp_q.delete(); obs_rd = obs_q.size();
  endtask

  task automatic test_odd_bytes();
    logic [15:0] e;
    int lbase;
    lbase = lerr_cnt;
    send_line(2 * HA + 1, 1'b1);
    send_line(2 * HA, 1'b1);
    drive_idle(4);
    tests_run++;
    if (lerr_cnt != lbase) begin failed++; $display("FAIL odd_line_err: got %0d pulses, required 0", lerr_cnt - lbase); end
    tests_run++;
    if (obs_q.size() - obs_rd != 2 * HA) begin failed++; $display("FAIL odd_strobes: got %0d, required %0d", obs_q.size() - obs_rd, 2 * HA); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); tests_run++;
      if (obs_q[obs_rd] !== e) begin failed++; $display("FAIL odd_pix[%0d]: got %h, required %h", obs_rd, obs_q[obs_rd], e); end
      obs_rd++;
    end
    exp_q.delete(); obs_rd = obs_q.size();
  endtask

  task automatic test_short_line();
    logic [7:0] b, hi;
    logic [15:0] e;
    int lbase;
    lbase = lerr_cnt; hi = '0;
    for (int i = 0; i < 2 * (HA - 1); i++) begin
      b = 8'($urandom);
      @(negedge clk); cam_href = 1'b1; cam_data = b;
      if (i % 2 == 0) hi = b; else exp_q.push_back({hi, b});
    end
    @(negedge clk); cam_href = 1'b0; cam_data = '0;
    @(negedge clk);
    tests_run++;
    if (line_err !== 1'b0) begin failed++; $display("FAIL short_err_early: got %b, required 0", line_err); end
    @(negedge clk);
    tests_run++;
    if (line_err !== 1'b1) begin failed++; $display("FAIL short_err_pulse: got %b, required 1", line_err); end
    @(negedge clk);
    tests_run++;
    if (line_err !== 1'b0) begin failed++; $display("FAIL short_err_width: got %b, required 0", line_err); end
    drive_idle(3);
    tests_run++;
    if (lerr_cnt - lbase != 1) begin failed++; $display("FAIL short_err_count: got %0d, required 1", lerr_cnt - lbase); end
    tests_run++;
    if (obs_q.size() - obs_rd != HA - 1) begin failed++; $display("FAIL short_strobes: got %0d, required %0d", obs_q.size() - obs_rd, HA - 1); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); tests_run++;
      if (obs_q[obs_rd] !== e) begin failed++; $display("FAIL short_pix[%0d]: got %h, required %h", obs_rd, obs_q[obs_rd], e); end
      obs_rd++;
    end
    exp_q.delete(); obs_rd = obs_q.size();
  endtask

  task automatic test_vsync_trunc();
    logic [7:0] b[5];
    logic [15:0] e;
    int lbase;
    lbase = lerr_cnt;
    for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); cam_href = 1'b1; cam_data = b[i]; cam_vsync = (i >= 3);
    end
    exp_q.push_back({b[0], b[1]});
    exp_q.push_back({b[3], b[4]});
    @(negedge clk); cam_href = 1'b0; cam_data = '0;
    drive_idle(2);
    @(negedge clk); cam_vsync = 1'b0;
    drive_idle(2);
    send_line(2 * HA, 1'b1);
    drive_idle(4);
    tests_run++;
    if (lerr_cnt != lbase) begin failed++; $display("FAIL trunc_line_err: got %0d pulses, required 0", lerr_cnt - lbase); end
    tests_run++;
    if (frame_ready !== 1'b1) begin failed++; $display("FAIL trunc_ready: got %b, required 1", frame_ready); end
    tests_run++;
    if (obs_q.size() - obs_rd != HA + 2) begin failed++; $display("FAIL trunc_strobes: got %0d, required %0d", obs_q.size() - obs_rd, HA + 2); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); tests_run++;
      if (obs_q[obs_rd] !== e) begin failed++; $display("FAIL trunc_pix[%0d]: got %h, required %h", obs_rd, obs_q[obs_rd], e); end
      obs_rd++;
    end
    exp_q.delete(); obs_rd = obs_q.size();
  endtask

  task automatic test_count_saturation();
    logic [15:0] e;
    int lbase;
    lbase = lerr_cnt;
    send_line(2 * (4096 + HA), 1'b1);
    drive_idle(4);
    tests_run++;
    if (lerr_cnt - lbase != 1) begin failed++; $display("FAIL sat_line_err: got %0d pulses, required 1", lerr_cnt - lbase); end
    tests_run++;
    if (obs_q.size() - obs_rd != 4096 + HA) begin failed++; $display("FAIL sat_strobes: got %0d, required %0d", obs_q.size() - obs_rd, 4096 + HA); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); tests_run++;
      if (obs_q[obs_rd] !== e) begin failed++; $display("FAIL sat_pix[%0d]: got %h, required %h", obs_rd, obs_q[obs_rd], e); end
      obs_rd++;
    end
    exp_q.delete(); obs_rd = obs_q.size();
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    int base;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); cam_href = 1'b1; cam_data = 8'($urandom);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({rgb_data_o, data_en_o, vs_o, de_o, frame_ready, line_err} !== 21'h0) begin
      failed++;
      $display("FAIL midrst_outputs: got rgb=%h en=%b vs=%b de=%b rdy=%b err=%b, required all 0",
               rgb_data_o, data_en_o, vs_o, de_o, frame_ready, line_err);
    end
    repeat (3) begin
      @(negedge clk); cam_data = 8'($urandom);
    end
    @(negedge clk); rst = 1'b1;
    exp_q.delete(); obs_rd = obs_q.size();
    repeat (4) begin
      @(negedge clk); cam_data = 8'($urandom);
    end
    @(negedge clk); cam_href = 1'b0; cam_data = '0;
    drive_idle(2);
    send_line(2 * HA, 1'b0);
    send_line(2 * HA, 1'b0);
    for (int f = 1; f <= 3; f++) begin
      base = obs_q.size();
      drive_frame((f == 3) ? 1 : 2, f == 3);
      drive_idle(4);
      tests_run++;
      if (frame_ready !== (f == 3)) begin failed++; $display("FAIL midrst_ready f%0d: got %b, required %b", f, frame_ready, (f == 3)); end
      if (f < 3) begin
        tests_run++;
        if (obs_q.size() != base) begin failed++; $display("FAIL midrst_strobes f%0d: got %0d, required 0", f, obs_q.size() - base); end
        obs_rd = obs_q.size();
      end
    end
    tests_run++;
    if (obs_q.size() - obs_rd != HA) begin failed++; $display("FAIL midrst_strobes f3: got %0d, required %0d", obs_q.size() - obs_rd, HA); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front(); tests_run++;
      if (obs_q[obs_rd] !== e) begin failed++; $display("FAIL midrst_pix[%0d]: got %h, required %h", obs_rd, obs_q[obs_rd], e); end
      obs_rd++;
    end
    exp_q.delete(); obs_rd = obs_q.size();
  endtask

  initial begin
    test_reset();
    test_frame_skip();
    test_latency();
    test_odd_bytes();
    test_short_line();
    test_vsync_trunc();
    test_count_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
